// File: rtl/credit_07_step1_pkg.sv
// Shared constants and types for the credit_07_step1 slice.
//   AXIS_DATA_W : width of the address stream payload (8)
//   MEM_DATA_W  : width of a RAM read word and of a FIFO word (16)
//   COUNT_W     : width of the FIFO occupancy count (depths up to 15)
package credit_07_step1_pkg;

    localparam int AXIS_DATA_W = 8;
    localparam int MEM_DATA_W  = 16;
    localparam int COUNT_W     = 4;

    typedef logic [AXIS_DATA_W-1:0] addr_t;
    typedef logic [MEM_DATA_W-1:0]  word_t;

    // Sum of the two RAM words; the carry out of bit 15 is dropped.
    function automatic word_t add_wrap(input word_t a, input word_t b);
        return a + b;
    endfunction

endpackage

// File: rtl/credit_07_step1_if.sv
// Interfaces used by credit_07_step1.
//   type_i_axis   : AXI-stream style channel (tdata, tvalid, tready, tlast)
//   type_i_mem_rd : synchronous RAM read port (addr, read, data one cycle later)
interface type_i_axis;
    import credit_07_step1_pkg::*;

    addr_t tdata;
    logic  tvalid;
    logic  tready;
    logic  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

interface type_i_mem_rd;
    import credit_07_step1_pkg::*;

    addr_t addr;
    logic  read;
    word_t data;

    modport master (output addr, output read, input data);
    modport slave  (input addr, input read, output data);
endinterface

// File: rtl/credit_07_step1_fifo.sv
// cr_fifo16: synchronous 16-bit FIFO with registered read data.
//   clk, reset_n : clock, asynchronous active-low reset
//   wr_en/wr_data: push one word (dropped and flagged when full)
//   rd_en        : pop one word; it appears on dout after the edge
//   dout         : last popped word, held between pops
//   full/empty   : decoded from count
//   overflow     : one-cycle pulse on a push while full
//   underflow    : one-cycle pulse on a pop while empty
//   count        : words held, 0..DEPTH
module cr_fifo16
    import credit_07_step1_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en,
    input  word_t              wr_data,
    input  logic               rd_en,
    output word_t              dout,
    output logic               full,
    output logic               empty,
    output logic               overflow,
    output logic               underflow,
    output logic [COUNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [COUNT_W-1:0] DEPTH_C  = COUNT_W'(DEPTH);

    word_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // NOTE: storage has no reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dout      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
            if (do_wr) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            count <= count + COUNT_W'(do_wr) - COUNT_W'(do_rd);
        end
    end

endmodule

// File: rtl/credit_07_step1.sv
// credit_07_step1: address stream -> dual RAM read -> summed word -> FIFO.
//   clk, reset_n      : clock, asynchronous active-low reset
//   stream_addr       : incoming read addresses (tlast unused)
//   ram0_rd, ram1_rd  : RAM read ports, same address, data one cycle later
//   fifo_rd_en        : pop one word from the output FIFO
//   fifo_dout         : popped word (registered)
//   fifo_full/empty   : FIFO occupancy flags
//   fifo_overflow     : pulse on a push into a full FIFO
//   fifo_underflow    : pulse on a pop from an empty FIFO
//   fifo_data_count   : words held
// Credit scheme: an address is only accepted while the words already in
// the FIFO plus the one read in flight leave room, so the FIFO can never
// be pushed while full.
module credit_07_step1
    import credit_07_step1_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    type_i_axis.slave           stream_addr,
    type_i_mem_rd.master        ram0_rd,
    type_i_mem_rd.master        ram1_rd,
    input  logic                fifo_rd_en,
    output word_t               fifo_dout,
    output logic                fifo_full,
    output logic                fifo_overflow,
    output logic                fifo_empty,
    output logic                fifo_underflow,
    output logic [COUNT_W-1:0]  fifo_data_count
);

    localparam logic [COUNT_W:0] CREDITS = (COUNT_W + 1)'(FIFO_DEPTH);

    logic             run_q;        // low during reset, high from the first edge after release
    logic             in_flight_q;  // RAM data for last cycle's accept arrives this cycle
    logic             accept;
    logic [COUNT_W:0] credits_used;
    word_t            sum_word;
    logic             unused_tlast;

    assign unused_tlast = stream_addr.tlast;

    // Ready depends only on registers, never on tvalid.
    assign credits_used      = {1'b0, fifo_data_count} + (COUNT_W + 1)'(in_flight_q);
    assign stream_addr.tready = run_q && (credits_used < CREDITS);
    assign accept            = stream_addr.tvalid && stream_addr.tready;

    assign ram0_rd.addr = stream_addr.tdata;
    assign ram1_rd.addr = stream_addr.tdata;
    assign ram0_rd.read = accept;
    assign ram1_rd.read = accept;

    assign sum_word = add_wrap(ram0_rd.data, ram1_rd.data);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q       <= 1'b0;
            in_flight_q <= 1'b0;
        end else begin
            run_q       <= 1'b1;
            in_flight_q <= accept;
        end
    end

    cr_fifo16 #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (in_flight_q),
        .wr_data   (sum_word),
        .rd_en     (fifo_rd_en),
        .dout      (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (fifo_overflow),
        .underflow (fifo_underflow),
        .count     (fifo_data_count)
    );

endmodule

// File: tb/tb_credit_07_step1.sv
// Directed self-checking bench for credit_07_step1 (FIFO_DEPTH = 8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_credit_07_step1;
    import credit_07_step1_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fifo_rd_en;
    word_t       fifo_dout;
    logic        fifo_full;
    logic        fifo_overflow;
    logic        fifo_empty;
    logic        fifo_underflow;
    logic [3:0]  fifo_data_count;

    type_i_axis   axis_if ();
    type_i_mem_rd ram0_if ();
    type_i_mem_rd ram1_if ();

    word_t ram0 [256];
    word_t ram1 [256];

    int n_pass  = 0;
    int n_total = 0;
    bit ovf_seen = 1'b0;

    always #5 clk = ~clk;

    credit_07_step1 #(
        .FIFO_DEPTH (8)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stream_addr     (axis_if),
        .ram0_rd         (ram0_if),
        .ram1_rd         (ram1_if),
        .fifo_rd_en      (fifo_rd_en),
        .fifo_dout       (fifo_dout),
        .fifo_full       (fifo_full),
        .fifo_overflow   (fifo_overflow),
        .fifo_empty      (fifo_empty),
        .fifo_underflow  (fifo_underflow),
        .fifo_data_count (fifo_data_count)
    );

    // Synchronous RAM models: data follows the strobe by one edge.
    always @(posedge clk) begin
        if (ram0_if.read) ram0_if.data <= ram0[ram0_if.addr];
        if (ram1_if.read) ram1_if.data <= ram1[ram1_if.addr];
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1 && fifo_overflow !== 1'b0) ovf_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        int    idx;
        bit    acc;
        addr_t a;

        for (int i = 0; i < 256; i++) begin
            ram0[i] = word_t'(i);
            ram1[i] = word_t'(i) << 8;
        end
        ram0[3] = 16'hFFFF;
        ram1[3] = 16'h0002;
        ram0_if.data = '0;
        ram1_if.data = '0;

        // ---- reset state (tvalid high must not produce strobes) ----
        reset_n = 1'b0;
        axis_if.tdata  = 8'h05;
        axis_if.tvalid = 1'b1;
        axis_if.tlast  = 1'b0;
        fifo_rd_en     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tready",    32'(axis_if.tready), 32'd0);
        chk("rst_read0",     32'(ram0_if.read), 32'd0);
        chk("rst_read1",     32'(ram1_if.read), 32'd0);
        chk("rst_empty",     32'(fifo_empty), 32'd1);
        chk("rst_full",      32'(fifo_full), 32'd0);
        chk("rst_count",     32'(fifo_data_count), 32'd0);
        chk("rst_dout",      32'(fifo_dout), 32'd0);
        chk("rst_overflow",  32'(fifo_overflow), 32'd0);
        chk("rst_underflow", 32'(fifo_underflow), 32'd0);

        axis_if.tvalid = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("tready_before_first_edge", 32'(axis_if.tready), 32'd0);
        @(negedge clk);
        chk("tready_after_release", 32'(axis_if.tready), 32'd1);

        // ---- addr 0x05 -> 0x0005 + 0x0500 = 0x0505 ----
        axis_if.tdata  = 8'h05;
        axis_if.tvalid = 1'b1;
        #1;
        chk("ram0_addr", 32'(ram0_if.addr), 32'h05);
        chk("ram1_addr", 32'(ram1_if.addr), 32'h05);
        chk("ram0_read", 32'(ram0_if.read), 32'd1);
        chk("ram1_read", 32'(ram1_if.read), 32'd1);
        @(negedge clk);                         // accept edge N
        axis_if.tvalid = 1'b0;
        #1;
        chk("read_drops", 32'(ram0_if.read), 32'd0);
        chk("empty_after_N", 32'(fifo_empty), 32'd1);
        @(negedge clk);                         // write edge N+1
        chk("empty_after_N1", 32'(fifo_empty), 32'd0);
        chk("count_after_N1", 32'(fifo_data_count), 32'd1);
        fifo_rd_en = 1'b1;
        @(negedge clk);
        fifo_rd_en = 1'b0;
        chk("dout_0505", 32'(fifo_dout), 32'h0505);
        chk("empty_after_pop", 32'(fifo_empty), 32'd1);

        // ---- addr 0x03 -> 0xFFFF + 0x0002 wraps to 0x0001 ----
        axis_if.tdata  = 8'h03;
        axis_if.tvalid = 1'b1;
        @(negedge clk);
        axis_if.tvalid = 1'b0;
        @(negedge clk);
        chk("count_wrap_word", 32'(fifo_data_count), 32'd1);
        fifo_rd_en = 1'b1;
        @(negedge clk);
        fifo_rd_en = 1'b0;
        chk("dout_wrap_0001", 32'(fifo_dout), 32'h0001);

        // ---- pop while empty ----
        fifo_rd_en = 1'b1;
        @(negedge clk);
        fifo_rd_en = 1'b0;
        chk("underflow_pulse", 32'(fifo_underflow), 32'd1);
        chk("underflow_count", 32'(fifo_data_count), 32'd0);
        chk("underflow_dout_held", 32'(fifo_dout), 32'h0001);
        @(negedge clk);
        chk("underflow_clears", 32'(fifo_underflow), 32'd0);

        // ---- fill: tvalid held for 12 cycles, addresses 0x10.. ----
        idx = 0;
        axis_if.tvalid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            axis_if.tdata = 8'h10 + addr_t'(idx);
            #1;
            acc = axis_if.tready;
            @(negedge clk);
            if (acc) idx++;
        end
        chk("fill_accepted", 32'(idx), 32'd8);
        chk("fill_tready", 32'(axis_if.tready), 32'd0);
        chk("fill_full", 32'(fifo_full), 32'd1);
        chk("fill_count", 32'(fifo_data_count), 32'd8);
        chk("fill_no_overflow", 32'(ovf_seen), 32'd0);

        // ---- pop one, one more address (0x18) gets in ----
        axis_if.tdata = 8'h18;
        fifo_rd_en = 1'b1;
        @(negedge clk);
        fifo_rd_en = 1'b0;
        chk("pop_first_word", 32'(fifo_dout), 32'h1010);
        chk("pop_tready_up", 32'(axis_if.tready), 32'd1);
        @(negedge clk);                         // 0x18 accepted
        axis_if.tvalid = 1'b0;
        chk("refill_tready_down", 32'(axis_if.tready), 32'd0);
        @(negedge clk);
        chk("refill_full", 32'(fifo_full), 32'd1);
        chk("refill_count", 32'(fifo_data_count), 32'd8);

        // ---- drain: words 0x1111 .. 0x1818 in order ----
        fifo_rd_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            a = 8'h11 + addr_t'(k);
            chk($sformatf("drain_%0d", k), 32'(fifo_dout), 32'({a, a}));
        end
        fifo_rd_en = 1'b0;
        chk("drain_empty", 32'(fifo_empty), 32'd1);
        chk("drain_no_overflow", 32'(ovf_seen), 32'd0);

        // ---- reset with 3 words stored and 1 in flight ----
        axis_if.tvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            axis_if.tdata = 8'h20 + addr_t'(k);
            @(negedge clk);
        end
        chk("pre_reset_count", 32'(fifo_data_count), 32'd3);
        reset_n = 1'b0;
        axis_if.tvalid = 1'b0;
        #1;
        chk("midrst_count", 32'(fifo_data_count), 32'd0);
        chk("midrst_empty", 32'(fifo_empty), 32'd1);
        chk("midrst_tready", 32'(axis_if.tready), 32'd0);
        chk("midrst_dout", 32'(fifo_dout), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("postrst_tready", 32'(axis_if.tready), 32'd1);
        chk("postrst_empty", 32'(fifo_empty), 32'd1);
        chk("postrst_count", 32'(fifo_data_count), 32'd0);
        repeat (2) @(negedge clk);
        chk("postrst_no_stale", 32'(fifo_data_count), 32'd0);
        chk("postrst_dout", 32'(fifo_dout), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/credit_07_step1.md
CREDIT_07_STEP1 -- requirements
Module: credit_07_step1

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: output FIFO capacity in words, range 2..15.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port stream_addr.tdata, input, 8 bits: read address.
REQ-005 SHALL have port stream_addr.tvalid, input, 1 bit: address valid.
REQ-006 SHALL have port stream_addr.tready, output, 1 bit: address accepted when tvalid and tready are both high.
REQ-007 SHALL have port stream_addr.tlast, input, 1 bit: ignored.
REQ-008 SHALL have ports ram0_rd.addr and ram1_rd.addr, output, 8 bits each: RAM read addresses.
REQ-009 SHALL have ports ram0_rd.read and ram1_rd.read, output, 1 bit each: RAM read strobes.
REQ-010 SHALL have ports ram0_rd.data and ram1_rd.data, input, 16 bits each: read data, valid one cycle after the strobe.
REQ-011 SHALL have port fifo_rd_en, input, 1 bit: pop one word.
REQ-012 SHALL have port fifo_dout, output, 16 bits: popped word.
REQ-013 SHALL have port fifo_full, output, 1 bit: high when count == FIFO_DEPTH.
REQ-014 SHALL have port fifo_overflow, output, 1 bit: one-cycle pulse on a write to a full FIFO.
REQ-015 SHALL have port fifo_empty, output, 1 bit: high when count == 0.
REQ-016 SHALL have port fifo_underflow, output, 1 bit: one-cycle pulse on a read from an empty FIFO.
REQ-017 SHALL have port fifo_data_count, output, 4 bits: words held, 0..FIFO_DEPTH.

Function
REQ-018 SHALL drive ram0_rd.addr and ram1_rd.addr combinationally from tdata, and assert both read strobes exactly when tvalid and tready are high.
REQ-019 SHALL hold a one-cycle in-flight flag set on each accept; in the following cycle it SHALL write ram0_rd.data + ram1_rd.data (mod 2^16, carry dropped) into the FIFO.
REQ-020 SHALL have a latency of an accept at edge N, FIFO write at edge N+1, and fifo_empty low after edge N+1.
REQ-021 SHALL use credit flow control: tready = (fifo_data_count + in_flight) < FIFO_DEPTH, combinational from registers only, independent of tvalid.
REQ-022 SHALL make overflow impossible by construction; a write to a full FIFO SHALL still be dropped and SHALL pulse fifo_overflow.
REQ-023 SHALL pop on fifo_rd_en while not empty and present the word on fifo_dout one cycle later (registered, not first-word-fall-through); fifo_dout holds its value otherwise.
REQ-024 SHALL ignore fifo_rd_en while empty, pulse fifo_underflow for one cycle, and leave count unchanged.
REQ-025 SHALL keep count unchanged on a simultaneous write and read with non-empty FIFO, and SHALL keep data ordered FIFO.
REQ-026 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH.
REQ-027 SHALL sustain back-to-back accepts at one per cycle while credits remain.

Reset
REQ-028 SHALL force while reset_n is low: tready=0, read strobes 0, in_flight=0, count=0, pointers=0, fifo_empty=1, fifo_full=0, fifo_overflow=0, fifo_underflow=0, fifo_dout=0.
REQ-029 SHALL discard any in-flight read and all FIFO contents on reset mid-operation; tready rises on the first edge after release.

Structure
REQ-030 SHALL take the interfaces type_i_axis (tdata, tvalid, tready, tlast) and type_i_mem_rd (addr, read, data) from the shared codebase package, with widths 8 and 16 as package constants.
REQ-031 SHALL implement the output FIFO as one sub-module, cr_fifo16 (storage, pointers, count, flags).

Verification
REQ-032 SHALL test: ram0[i]=i, ram1[i]=i<<8, send addr 0x05 -> one FIFO word 0x0505, visible 2 edges after accept.
REQ-033 SHALL test: ram0[3]=0xFFFF, ram1[3]=0x0002, send 0x03 -> word 0x0001 (wrap).
REQ-034 SHALL test: no reads, 10 addresses with tvalid held high -> exactly 8 accepted, tready low, fifo_full=1, count=8, overflow never pulses.
REQ-035 SHALL test: then pop one word -> tready rises next cycle, one more address accepted, full again; data order matches send order.
REQ-036 SHALL test: fifo_rd_en while empty -> fifo_underflow high for 1 cycle, count stays 0.
REQ-037 SHALL test: reset_n low with 3 words stored plus 1 in flight -> after release empty=1, count=0, no stale word appears.
